// File: rtl/spi_reg_master.sv
// SPI mode-0 slave that turns host frames {rw, adr, data} into register-bus writes
// and streams register readback on miso, all oversampled in the clock domain.
module spi_reg_master #(
  parameter int ADRSIZE = 8,
  parameter int REGSIZE = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  output logic [ADRSIZE-1:0] adr,
  output logic [REGSIZE-1:0] bus_wr,
  output logic               wr,
  input  logic [REGSIZE-1:0] bus_rd,
  output logic               busy,
  output logic               frame_err
);
  localparam int MAXB = (ADRSIZE > REGSIZE) ? ADRSIZE : REGSIZE;
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {IDLE, RW, ADDR, DATA, DONE} state_t;

  // [0],[1] synchroniser stages, [2] history for edge detection
  logic [2:0] sclk_sq, sclk_sd, cs_sq, cs_sd;
  logic [1:0] mosi_sq, mosi_sd;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [ADRSIZE-1:0] addr_sr_q, addr_sr_d, adr_q, adr_d;
  logic [REGSIZE-1:0] rx_q, rx_d, tx_q, tx_d, bus_wr_q, bus_wr_d;
  logic               tx_vld_q, tx_vld_d;
  logic [1:0]         cap_pipe_q, cap_pipe_d;
  logic               wr_pend_q, wr_pend_d, wr_q, wr_d, frame_err_q, frame_err_d;

  logic rise, fall, cs_s, cs_fall, mosi_s;

  always_comb begin
    sclk_sd = {sclk_sq[1:0], sclk};
    cs_sd   = {cs_sq[1:0], cs_n};
    mosi_sd = {mosi_sq[0], mosi};
  end

  assign rise    = sclk_sq[1] & ~sclk_sq[2];
  assign fall    = ~sclk_sq[1] & sclk_sq[2];
  assign cs_s    = cs_sq[1];
  assign cs_fall = cs_sq[2] & ~cs_sq[1];
  assign mosi_s  = mosi_sq[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_sr_d   = addr_sr_q;
    adr_d       = adr_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    tx_vld_d    = tx_vld_q;
    bus_wr_d    = bus_wr_q;
    cap_pipe_d  = {cap_pipe_q[0], 1'b0};
    wr_pend_d   = 1'b0;
    wr_d        = wr_pend_q;
    frame_err_d = 1'b0;

    // readback sampled two cycles after adr moves so the external mux has settled
    if (cap_pipe_q[1]) begin
      tx_d     = bus_rd;
      tx_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        tx_vld_d = 1'b0;
        if (cs_fall) state_d = RW;
      end
      RW, ADDR, DATA: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          cap_pipe_d  = '0;
        end else if (state_q == RW) begin
          if (rise) begin
            rw_d    = mosi_s;
            cnt_d   = '0;
            state_d = ADDR;
          end
        end else if (state_q == ADDR) begin
          if (rise) begin
            addr_sr_d = {addr_sr_q[ADRSIZE-2:0], mosi_s};
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CW'(ADRSIZE - 1)) begin
              adr_d         = addr_sr_d;
              cnt_d         = '0;
              cap_pipe_d[0] = ~rw_q;
              state_d       = DATA;
            end
          end
        end else begin
          if (rise) begin
            cnt_d = cnt_q + CW'(1);
            if (rw_q) rx_d = {rx_q[REGSIZE-2:0], mosi_s};
            if (cnt_q == CW'(REGSIZE - 1)) begin
              state_d = DONE;
              if (rw_q) begin
                bus_wr_d  = rx_d;
                wr_pend_d = 1'b1;
              end
            end
          end else if (fall && !rw_q && cnt_q != '0) begin
            // the fall right after the last address bit must not shift: MSB is still unread
            tx_d = {tx_q[REGSIZE-2:0], 1'b0};
          end
        end
      end
      DONE: if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sq     <= '0;
      cs_sq       <= '0;  // looks "selected" so a frame already in flight at release is skipped
      mosi_sq     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_sr_q   <= '0;
      adr_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      tx_vld_q    <= 1'b0;
      bus_wr_q    <= '0;
      cap_pipe_q  <= '0;
      wr_pend_q   <= 1'b0;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sq     <= sclk_sd;
      cs_sq       <= cs_sd;
      mosi_sq     <= mosi_sd;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_sr_q   <= addr_sr_d;
      adr_q       <= adr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      tx_vld_q    <= tx_vld_d;
      bus_wr_q    <= bus_wr_d;
      cap_pipe_q  <= cap_pipe_d;
      wr_pend_q   <= wr_pend_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign adr       = adr_q;
  assign bus_wr    = bus_wr_q;
  assign wr        = wr_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE) & ~cs_s;
  assign miso_oe   = busy;
  assign miso      = (state_q == DATA) & ~rw_q & tx_vld_q & tx_q[REGSIZE-1];
endmodule

// File: tb/tb_spi_reg_master.sv
// Directed + randomized frames against a frame-level model of the SPI register master.
module tb_spi_reg_master;
  localparam int HP = 5;  // sclk half period in clocks -> sclk = clock/10

  logic        clock = 1'b0, reset = 1'b1;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe, wr, busy, frame_err;
  logic [7:0]  adr;
  logic [31:0] bus_wr, bus_rd;

  logic [7:0]  rd_adr = 8'h12;
  logic [31:0] rd_val = 32'hCAFEF00D;
  assign bus_rd = (adr == rd_adr) ? rd_val : 32'h0;

  spi_reg_master #(.ADRSIZE(8), .REGSIZE(32)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .adr(adr), .bus_wr(bus_wr), .wr(wr),
    .bus_rd(bus_rd), .busy(busy), .frame_err(frame_err));

  always #5 clock = ~clock;

  int wr_cnt = 0, ferr_cnt = 0, wr_run = 0, wr_maxw = 0;
  always @(negedge clock) begin
    wr_cnt   <= wr_cnt + (wr ? 1 : 0);
    ferr_cnt <= ferr_cnt + (frame_err ? 1 : 0);
    wr_run   <= wr ? wr_run + 1 : 0;
    if (wr && wr_run + 1 > wr_maxw) wr_maxw <= wr_run + 1;
  end

  int checks = 0, errors = 0;
  logic [7:0]  m_adr = 8'h0;
  logic [31:0] m_bus = 32'h0;
  int          exp_wr = 0, exp_ferr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host side: sends the first nbits of {rw,adr,data} plus extra junk bits, collecting miso at data rises.
  task automatic xfer(input logic [40:0] fr, input int nbits, input int extra,
                      input bit end_frame, output logic [31:0] rd);
    rd   = 32'h0;
    cs_n = 1'b0;
    repeat (HP) @(negedge clock);
    for (int i = 0; i < nbits + extra; i++) begin
      if (i < 41) mosi = fr[40-i];
      else        mosi = 1'($urandom);
      repeat (HP) @(negedge clock);
      if (i >= 9 && i < 41) rd = {rd[30:0], miso};
      sclk = 1'b1;
      repeat (HP) @(negedge clock);
      sclk = 1'b0;
    end
    if (end_frame) begin
      repeat (HP) @(negedge clock);
      cs_n = 1'b1;
    end
  endtask

  task automatic post(input string tag);
    repeat (8) @(negedge clock);
    chk({tag, ".adr"}, 64'(adr), 64'(m_adr));
    chk({tag, ".bus_wr"}, 64'(bus_wr), 64'(m_bus));
    chk({tag, ".wr_cnt"}, 64'(wr_cnt), 64'(exp_wr));
    chk({tag, ".ferr_cnt"}, 64'(ferr_cnt), 64'(exp_ferr));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".adr"}, 64'(adr), 64'(0));
    chk({tag, ".bus_wr"}, 64'(bus_wr), 64'(0));
    chk({tag, ".wr"}, 64'(wr), 64'(0));
    chk({tag, ".miso"}, 64'(miso), 64'(0));
    chk({tag, ".miso_oe"}, 64'(miso_oe), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".frame_err"}, 64'(frame_err), 64'(0));
  endtask

  initial begin
    logic [31:0] rd, d, d2;
    logic [7:0]  a;
    bit          rw;

    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_reset("reset");

    // basic write
    xfer({1'b1, 8'h05, 32'hDEADBEEF}, 41, 0, 1, rd);
    m_adr = 8'h05; m_bus = 32'hDEADBEEF; exp_wr++;
    post("write05");
    chk("write05.wr_width", 64'(wr_maxw), 64'(1));

    // basic read
    xfer({1'b0, 8'h12, 32'h0}, 41, 0, 1, rd);
    m_adr = 8'h12;
    chk("read12.data", 64'(rd), 64'(32'hCAFEF00D));
    post("read12");

    // abort in the data phase
    xfer({1'b1, 8'h07, 32'h12345678}, 20, 0, 1, rd);
    m_adr = 8'h07; exp_ferr++;
    post("abort07");
    d = $urandom; a = 8'($urandom);
    xfer({1'b1, a, d}, 41, 0, 1, rd);
    m_adr = a; m_bus = d; exp_wr++;
    post("after_abort");

    // overlong write frame
    d = $urandom; a = 8'($urandom);
    xfer({1'b1, a, d}, 41, 8, 1, rd);
    m_adr = a; m_bus = d; exp_wr++;
    post("overlong");

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      rw = 1'($urandom); a = 8'($urandom); d = $urandom;
      rd_adr = a; rd_val = $urandom;
      xfer({rw, a, d}, 41, 0, 1, rd);
      m_adr = a;
      if (rw) begin m_bus = d; exp_wr++; end
      else chk("rand.read_data", 64'(rd), 64'(rd_val));
      post("rand");
    end

    // reset in the middle of the data phase, cs_n held low through and after reset
    xfer({1'b1, 8'h33, 32'hA5A5A5A5}, 30, 0, 0, rd);
    chk("midreset.busy_before", 64'(busy), 64'(1));
    chk("midreset.miso_oe_before", 64'(miso_oe), 64'(1));
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_reset("midreset");
    m_adr = 8'h0; m_bus = 32'h0;
    xfer(41'h0_FF_FFFFFFFF, 11, 0, 1, rd);
    post("midreset_tail");
    d = $urandom;
    xfer({1'b1, 8'h44, d}, 41, 0, 1, rd);
    m_adr = 8'h44; m_bus = d; exp_wr++;
    post("after_reset");

    // back-to-back writes with a short deselect gap
    d = $urandom; d2 = $urandom;
    xfer({1'b1, 8'h01, d}, 41, 0, 1, rd);
    chk("b2b.first_adr", 64'(adr), 64'(8'h01));
    chk("b2b.first_bus_wr", 64'(bus_wr), 64'(d));
    chk("b2b.first_wr_cnt", 64'(wr_cnt), 64'(exp_wr + 1));
    repeat (3) @(negedge clock);
    xfer({1'b1, 8'h02, d2}, 41, 0, 1, rd);
    m_adr = 8'h02; m_bus = d2; exp_wr += 2;
    post("b2b");
    chk("final.wr_width", 64'(wr_maxw), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
